// File: rtl/grf_scoreboard.sv
// grf_scoreboard: per-register write-pending scoreboard driving the decode stall and forward-select hints.
module grf_scoreboard #(
  parameter int LAT_W = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid,
  input  logic [4:0]       dec_rs,
  input  logic [4:0]       dec_rt,
  input  logic             dec_use_rs,
  input  logic             dec_use_rt,
  input  logic             dec_wr,
  input  logic [4:0]       dec_dst,
  input  logic [LAT_W-1:0] dec_lat,
  input  logic             wb_we,
  input  logic [4:0]       wb_a3,
  output logic             stall,
  output logic             fwd_rs,
  output logic             fwd_rt,
  output logic [5:0]       pend_cnt,
  output logic [CNT_W-1:0] stall_cnt
);
  logic [31:0] pending, pend_nx;
  logic [31:0][LAT_W-1:0] cnt, cnt_nx;
  logic raw, waw, issue;
  // pending[0] is never set, so register 0 reads as idle everywhere
  assign raw = (dec_use_rs && pending[dec_rs] && cnt[dec_rs] != '0) ||
               (dec_use_rt && pending[dec_rt] && cnt[dec_rt] != '0);
  assign waw = dec_wr && dec_dst != '0 && pending[dec_dst] && cnt[dec_dst] > dec_lat;
  assign stall = dec_valid && (raw || waw);
  assign issue = dec_valid && !stall;
  assign fwd_rs = dec_use_rs && pending[dec_rs] && cnt[dec_rs] == '0 && !(wb_we && wb_a3 == dec_rs);
  assign fwd_rt = dec_use_rt && pending[dec_rt] && cnt[dec_rt] == '0 && !(wb_we && wb_a3 == dec_rt);
  always_comb begin
    pend_nx = pending;
    cnt_nx = cnt;
    for (int i = 1; i < 32; i++) begin
      if (issue && dec_wr && dec_dst == 5'(i)) begin
        pend_nx[i] = 1'b1;
        cnt_nx[i] = dec_lat;
      end else if (wb_we && wb_a3 == 5'(i)) begin
        pend_nx[i] = 1'b0;
        cnt_nx[i] = '0;
      end else begin
        cnt_nx[i] = cnt[i] != '0 ? cnt[i] - LAT_W'(1) : cnt[i];
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      cnt <= '0;
      pend_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      pending <= pend_nx;
      cnt <= cnt_nx;
      pend_cnt <= 6'($countones(pend_nx));
      stall_cnt <= (stall && !(&stall_cnt)) ? stall_cnt + CNT_W'(1) : stall_cnt;
    end
  end
endmodule

// File: tb/tb_grf_scoreboard.sv
// tb_grf_scoreboard: directed and random stimulus checked against a ready-time model of the scoreboard.
module tb_grf_scoreboard;
  localparam int CW = 4;
  logic clk = 0, reset = 0;
  logic dec_valid = 0, dec_use_rs = 0, dec_use_rt = 0, dec_wr = 0, wb_we = 0;
  logic [4:0] dec_rs = 0, dec_rt = 0, dec_dst = 0, wb_a3 = 0;
  logic [1:0] dec_lat = 0;
  logic stall, fwd_rs, fwd_rt;
  logic [5:0] pend_cnt;
  logic [CW-1:0] stall_cnt;
  int total = 0, passed = 0;
  // model: a pending register becomes forwardable at absolute cycle rdy[r]
  int cyc = 0, msc = 0;
  bit mp[32];
  int rdy[32];

  grf_scoreboard #(.LAT_W(2), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
    .dec_use_rs(dec_use_rs), .dec_use_rt(dec_use_rt), .dec_wr(dec_wr), .dec_dst(dec_dst),
    .dec_lat(dec_lat), .wb_we(wb_we), .wb_a3(wb_a3), .stall(stall), .fwd_rs(fwd_rs),
    .fwd_rt(fwd_rt), .pend_cnt(pend_cnt), .stall_cnt(stall_cnt));

  always #5 clk = ~clk;

  function automatic bit pend(int r);
    return r != 0 && mp[r];
  endfunction
  function automatic int rem(int r);
    return (pend(r) && rdy[r] > cyc) ? rdy[r] - cyc : 0;
  endfunction
  function automatic bit m_stall();
    bit raw = (dec_use_rs && rem(int'(dec_rs)) > 0) || (dec_use_rt && rem(int'(dec_rt)) > 0);
    bit waw = dec_wr && pend(int'(dec_dst)) && rem(int'(dec_dst)) > int'(dec_lat);
    return dec_valid && (raw || waw);
  endfunction
  function automatic bit m_fwd(bit use_r, int r);
    return use_r && pend(r) && rem(r) == 0 && !(wb_we && int'(wb_a3) == r);
  endfunction
  function automatic int m_pcnt();
    int n = 0;
    for (int r = 1; r < 32; r++) n += int'(mp[r]);
    return n;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++) mp[r] = 0;
    msc = 0;
  endtask
  task automatic model_step();
    bit st = m_stall();
    for (int r = 1; r < 32; r++) begin
      if (dec_valid && !st && dec_wr && int'(dec_dst) == r) begin
        mp[r] = 1;
        rdy[r] = cyc + 1 + int'(dec_lat);
      end else if (wb_we && int'(wb_a3) == r) mp[r] = 0;
    end
    if (st && msc < (1 << CW) - 1) msc++;
    cyc++;
  endtask

  task automatic chk(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    chk("stall", int'(stall), int'(m_stall()));
    chk("pend_cnt", int'(pend_cnt), m_pcnt());
    chk("stall_cnt", int'(stall_cnt), msc);
    if (!m_stall()) begin
      chk("fwd_rs", int'(fwd_rs), int'(m_fwd(dec_use_rs, int'(dec_rs))));
      chk("fwd_rt", int'(fwd_rt), int'(m_fwd(dec_use_rt, int'(dec_rt))));
    end
  end

  task automatic tick();
    @(posedge clk);
    if (reset) model_step();
    #1;
  endtask
  task automatic set(bit v, int rs, int rt, bit urs, bit urt, bit wr, int dst, int lat, bit we, int a3);
    dec_valid = v; dec_rs = 5'(rs); dec_rt = 5'(rt); dec_use_rs = urs; dec_use_rt = urt;
    dec_wr = wr; dec_dst = 5'(dst); dec_lat = 2'(lat); wb_we = we; wb_a3 = 5'(a3);
    #3;
  endtask

  initial begin
    model_clear();
    tick();
    tick();
    reset = 1;
    set(1, 3, 4, 1, 1, 0, 0, 0, 0, 0);
    chk("rst_stall", int'(stall), 0);
    chk("rst_fwd_rs", int'(fwd_rs), 0);
    chk("rst_fwd_rt", int'(fwd_rt), 0);
    chk("rst_pend", int'(pend_cnt), 0);
    tick();
    set(1, 0, 0, 0, 0, 1, 5, 2, 0, 0);
    tick();
    set(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("raw5_c1", int'(stall), 1);
    chk("model_raw5", int'(m_stall()), 1);
    tick();
    chk("raw5_c2", int'(stall), 1);
    tick();
    chk("raw5_go", int'(stall), 0);
    chk("raw5_fwd", int'(fwd_rs), 1);
    chk("raw5_scnt", int'(stall_cnt), 2);
    chk("raw5_pend", int'(pend_cnt), 1);
    tick();
    set(0, 0, 0, 0, 0, 0, 0, 0, 1, 5);
    tick();
    set(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
    tick();
    set(1, 7, 0, 1, 0, 0, 0, 0, 1, 7);
    chk("wb7_stall", int'(stall), 0);
    chk("wb7_fwd", int'(fwd_rs), 0);
    tick();
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("wb7_pend", int'(pend_cnt), 0);
    set(1, 0, 0, 0, 0, 1, 9, 3, 0, 0);
    tick();
    set(1, 0, 0, 0, 0, 1, 9, 0, 0, 0);
    chk("waw_c1", int'(stall), 1);
    tick();
    chk("waw_c2", int'(stall), 1);
    tick();
    chk("waw_c3", int'(stall), 1);
    tick();
    chk("waw_go", int'(stall), 0);
    tick();
    chk("waw_pend", int'(pend_cnt), 1);
    chk("model_waw_pend", m_pcnt(), 1);
    set(0, 0, 0, 0, 0, 0, 0, 0, 1, 9);
    tick();
    set(1, 0, 0, 0, 0, 1, 2, 1, 1, 2);
    tick();
    set(1, 0, 2, 0, 1, 0, 0, 0, 0, 0);
    chk("same2_stall", int'(stall), 1);
    tick();
    chk("same2_go", int'(stall), 0);
    chk("same2_fwd", int'(fwd_rt), 1);
    tick();
    set(0, 0, 0, 0, 0, 0, 0, 0, 1, 2);
    tick();
    for (int r = 10; r < 13; r++) begin
      set(1, 0, 0, 0, 0, 1, r, 3, 0, 0);
      tick();
    end
    set(1, 10, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("pre_rst_stall", int'(stall), 1);
    chk("pre_rst_pend", int'(pend_cnt), 3);
    reset = 0;
    model_clear();
    #1;
    chk("async_stall", int'(stall), 0);
    chk("async_pend", int'(pend_cnt), 0);
    chk("async_scnt", int'(stall_cnt), 0);
    tick();
    reset = 1;
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        reset = 0;
        model_clear();
      end else if (n == 1503) reset = 1;
      set($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 7),
          1'($urandom), 1'($urandom), $urandom_range(0, 9) < 6, $urandom_range(0, 7),
          $urandom_range(0, 3), $urandom_range(0, 9) < 3, $urandom_range(0, 7));
      tick();
    end
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
